// File: rtl/bdd_pkg.sv
// bdd_pkg: shared widths, node word layout and FSM encoding for the
// sequential BDD evaluator.
//
// Optional feature macro: BDD_COMPLEMENT_EDGES_EN
//   defined   -> node words carry lo_neg/hi_neg and parity accumulates
//   undefined -> no complement bits, the result is the terminal value
package bdd_pkg;

    localparam int IN_W   = 16;
    localparam int NODES  = 256;
    localparam int ADDR_W = $clog2(NODES);
    localparam int SEL_W  = $clog2(IN_W);
    // One code above IN_W-1 must fit in the variable field so an out-of-range
    // variable can be written into the table and caught during the walk.
    localparam int VAR_W  = $clog2(IN_W + 1);
    // Step counter has to reach IN_W+1, the visit count that flags a loop.
    localparam int STEP_W = $clog2(IN_W + 2);

`ifdef BDD_COMPLEMENT_EDGES_EN
    localparam int NODE_W = 2 + VAR_W + 2*ADDR_W + 2;

    typedef struct packed {
        logic              hi_neg;
        logic              lo_neg;
        logic              is_term;
        logic              term_val;
        logic [VAR_W-1:0]  var_idx;
        logic [ADDR_W-1:0] hi_ptr;
        logic [ADDR_W-1:0] lo_ptr;
    } node_t;
`else
    localparam int NODE_W = 2 + VAR_W + 2*ADDR_W;

    typedef struct packed {
        logic              is_term;
        logic              term_val;
        logic [VAR_W-1:0]  var_idx;
        logic [ADDR_W-1:0] hi_ptr;
        logic [ADDR_W-1:0] lo_ptr;
    } node_t;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EVAL  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/bdd_node_ram.sv
// bdd_node_ram: single-port node table, NODES x NODE_W, synchronous read.
// Contents are deliberately not reset so a table survives a controller reset.
//
// Ports:
//   clk    in  clock, rising edge
//   we     in  write strobe (writes wdata to addr)
//   re     in  read strobe (registers mem[addr] into rdata)
//   addr   in  node index shared by read and write
//   wdata  in  node word to store
//   rdata  out registered node word, held while re is low
module bdd_node_ram
    import bdd_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [NODE_W-1:0] wdata,
    output logic [NODE_W-1:0] rdata
);

    logic [NODE_W-1:0] mem [NODES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/bdd_eval_seq.sv
// bdd_eval_seq: table-driven BDD evaluator. Each accepted input vector is
// walked from cfg_root through the node RAM, one node per FETCH/EVAL pair,
// until a terminal, an illegal variable or the loop guard ends the walk.
//
// Optional feature macro: BDD_COMPLEMENT_EDGES_EN (complement edges with
// parity accumulated along the path).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   cfg_we/addr/wdata      node table write, honoured only while cfg_ready
//   cfg_ready              high in IDLE
//   cfg_root               root index, sampled when an input is accepted
//   in_valid/in_ready      input handshake, in_data bit i is variable i
//   out_valid/out_ready    result handshake
//   out_data               function value
//   out_err                walk aborted (illegal variable or loop guard)
module bdd_eval_seq
    import bdd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [NODE_W-1:0] cfg_wdata,
    input  logic [ADDR_W-1:0] cfg_root,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_data,
    output logic              out_err
);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] FETCH = ST_FETCH;
    localparam logic [1:0] EVAL  = ST_EVAL;
    localparam logic [1:0] DONE  = ST_DONE;

    logic [1:0]        state;
    logic [IN_W-1:0]   in_reg;
    logic [ADDR_W-1:0] ptr;
    logic [STEP_W-1:0] steps;
    logic              parity;
    logic [NODE_W-1:0] rdata;
    node_t             node;
    logic              sel_hi;
    logic              sel_neg;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;

    // The RAM port is shared: config writes own it in IDLE, walk reads own
    // it otherwise, so table contents can only change between walks.
    assign ram_we   = cfg_we && (state == IDLE);
    assign ram_re   = (state == FETCH);
    assign ram_addr = (state == IDLE) ? cfg_addr : ptr;

    bdd_node_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (cfg_wdata),
        .rdata (rdata)
    );

    assign node   = rdata;
    // Only consulted once var_idx is known to be in range.
    assign sel_hi = in_reg[node.var_idx[SEL_W-1:0]];

`ifdef BDD_COMPLEMENT_EDGES_EN
    assign sel_neg = sel_hi ? node.hi_neg : node.lo_neg;
`else
    assign sel_neg = 1'b0;
    assign parity  = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign cfg_ready = (state == IDLE);

    // Walk controller. Checks in EVAL are ordered: a terminal always wins,
    // then an out-of-range variable, then the loop guard. out_valid rises one
    // cycle after entering DONE so the result word is already stable when it
    // is presented, and it is cleared on the same edge that returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_reg    <= '0;
            ptr       <= '0;
            steps     <= '0;
            out_valid <= 1'b0;
            out_data  <= 1'b0;
            out_err   <= 1'b0;
`ifdef BDD_COMPLEMENT_EDGES_EN
            parity    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_reg <= in_data;
                        ptr    <= cfg_root;
                        steps  <= '0;
`ifdef BDD_COMPLEMENT_EDGES_EN
                        parity <= 1'b0;
`endif
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    steps <= steps + 1'b1;
                    state <= EVAL;
                end
                EVAL: begin
                    if (node.is_term) begin
                        out_data <= node.term_val ^ parity;
                        out_err  <= 1'b0;
                        state    <= DONE;
                    end else if (node.var_idx >= VAR_W'(IN_W)) begin
                        out_data <= 1'b0;
                        out_err  <= 1'b1;
                        state    <= DONE;
                    end else if (steps == STEP_W'(IN_W + 1)) begin
                        out_data <= 1'b0;
                        out_err  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        ptr   <= sel_hi ? node.hi_ptr : node.lo_ptr;
`ifdef BDD_COMPLEMENT_EDGES_EN
                        parity <= parity ^ sel_neg;
`endif
                        state <= FETCH;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bdd_eval_seq.sv
// tb_bdd_eval_seq: self-checking bench for bdd_eval_seq. Directed tables
// (terminal root, AND chain, parity, loop, illegal variable, backpressure)
// followed by random tables, all checked against a path-walking model.
module tb_bdd_eval_seq;
    import bdd_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_addr;
    logic [NODE_W-1:0] cfg_wdata;
    logic [ADDR_W-1:0] cfg_root;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_data;
    logic              out_err;

    int checks = 0;
    int errors = 0;

    logic [NODE_W-1:0] model_mem [NODES];

    // Side-channel writes driven by applyStimulus: a write that lands during
    // the hold phase (must be dropped) or together with acceptance (must land).
    logic              drop_en = 1'b0;
    logic [ADDR_W-1:0] drop_addr = '0;
    logic [NODE_W-1:0] drop_word = '0;
    logic              co_en = 1'b0;
    logic [ADDR_W-1:0] co_addr = '0;
    logic [NODE_W-1:0] co_word = '0;

    bdd_eval_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_root  (cfg_root),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Node word built from the documented field order, LSB first.
    function automatic logic [NODE_W-1:0] mkNode(input int lo, input int hi, input int v,
                                                 input int tv, input int term, input int negs);
        logic [NODE_W-1:0] w;
        w = '0;
        w[ADDR_W-1:0]          = lo[ADDR_W-1:0];
        w[2*ADDR_W-1:ADDR_W]   = hi[ADDR_W-1:0];
        w[2*ADDR_W +: VAR_W]   = v[VAR_W-1:0];
        w[2*ADDR_W + VAR_W]     = tv[0];
        w[2*ADDR_W + VAR_W + 1] = term[0];
`ifdef BDD_COMPLEMENT_EDGES_EN
        w[2*ADDR_W + VAR_W + 2] = negs[0];
        w[2*ADDR_W + VAR_W + 3] = negs[1];
`else
        if (negs != 0) $display("[TB] note: complement bits ignored in this build");
`endif
        return w;
    endfunction

    // Reference walk: follows the graph in model_mem and reports the value,
    // the abort flag and the number of nodes visited.
    function automatic void modelWalk(input logic [IN_W-1:0] din, input int root,
                                      output int d, output int e, output int visits);
        int p;
        int par;
        logic [NODE_W-1:0] w;
        int lo, hi, v, tv, term, lon, hin;
        p = root; par = 0; d = 0; e = 0; visits = 0;
        for (int k = 1; k <= IN_W + 1; k++) begin
            w    = model_mem[p];
            visits = k;
            lo   = int'(w[ADDR_W-1:0]);
            hi   = int'(w[2*ADDR_W-1:ADDR_W]);
            v    = int'(w[2*ADDR_W +: VAR_W]);
            tv   = int'(w[2*ADDR_W + VAR_W]);
            term = int'(w[2*ADDR_W + VAR_W + 1]);
            lon  = 0;
            hin  = 0;
`ifdef BDD_COMPLEMENT_EDGES_EN
            lon  = int'(w[2*ADDR_W + VAR_W + 2]);
            hin  = int'(w[2*ADDR_W + VAR_W + 3]);
`endif
            if (term != 0) begin d = tv ^ par; e = 0; return; end
            if (v >= IN_W) begin d = 0; e = 1; return; end
            if (k == IN_W + 1) begin d = 0; e = 1; return; end
            if (din[v]) begin p = hi; par = par ^ hin; end
            else begin p = lo; par = par ^ lon; end
        end
    endfunction

    task automatic cfgWrite(input int addr, input logic [NODE_W-1:0] word);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_addr  = addr[ADDR_W-1:0];
        cfg_wdata = word;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        model_mem[addr] = word;
    endtask

    // One complete walk: accept, time the result, optionally hold out_ready
    // low for `hold` cycles, then release and confirm the return to IDLE.
    task automatic applyStimulus(input logic [IN_W-1:0] din, input int root, input int hold,
                                 output int obs_d, output int obs_e, output int cyc);
        @(negedge clk);
        checkOutput("accept_ready", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = din;
        cfg_root  = root[ADDR_W-1:0];
        out_ready = (hold == 0);
        if (co_en) begin
            cfg_we    = 1'b1;
            cfg_addr  = co_addr;
            cfg_wdata = co_word;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        cyc = 0;
        while (1) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) break;
            if (cyc >= 100) begin
                checkOutput("walk_timeout", 1, 0);
                break;
            end
        end
        obs_d = int'(out_data);
        obs_e = int'(out_err);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cfg_we    = drop_en;
            cfg_addr  = drop_addr;
            cfg_wdata = drop_word;
            @(posedge clk);
            #1;
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_result", {out_err, out_data}, {obs_e[0], obs_d[0]});
        end
        @(negedge clk);
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release_valid", out_valid, 0);
        checkOutput("release_ready", in_ready, 1);
    endtask

    task automatic runWalk(input string tag, input logic [IN_W-1:0] din, input int root,
                           input int hold);
        int ed, ee, ev, od, oe, cyc;
        modelWalk(din, root, ed, ee, ev);
        applyStimulus(din, root, hold, od, oe, cyc);
        checkOutput({tag, "_err"}, oe, ee);
        if (ee == 0) checkOutput({tag, "_data"}, od, ed);
        checkOutput({tag, "_latency"}, cyc, 2*ev + 1);
    endtask

    initial begin
        int od, oe, cyc, negs;
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        cfg_root  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < NODES; i++) model_mem[i] = '0;

        #23;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_cfg_ready", cfg_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_err", out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed tables: AND chain on nodes 0-3, terminals 4/5, loop, illegal var.
        for (int i = 0; i < 4; i++) cfgWrite(i, mkNode(5, (i == 3) ? 4 : i + 1, 3 - i, 0, 0, 0));
        cfgWrite(4, mkNode(0, 0, 0, 1, 1, 0));
        cfgWrite(5, mkNode(0, 0, 0, 0, 1, 0));
        cfgWrite(6, mkNode(6, 6, 0, 0, 0, 0));
        cfgWrite(7, mkNode(4, 4, 20, 0, 0, 0));

        // Reset in the middle of a long walk, then a root-terminal walk.
        @(negedge clk);
        in_valid = 1'b1;
        cfg_root = 8'd6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", in_ready, 1);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_err", out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h0000, 4, 0, od, oe, cyc);
        checkOutput("root_term_data", od, 1);
        checkOutput("root_term_latency", cyc, 3);

        applyStimulus(16'h000F, 0, 0, od, oe, cyc);
        checkOutput("and_f_data", od, 1);
        checkOutput("and_f_latency", cyc, 11);
        applyStimulus(16'h0007, 0, 0, od, oe, cyc);
        checkOutput("and_7_data", od, 0);
        checkOutput("and_7_latency", cyc, 5);
        runWalk("and_rand", 16'($urandom), 0, 0);

        applyStimulus(16'h1234, 6, 0, od, oe, cyc);
        checkOutput("loop_err", oe, 1);
        checkOutput("loop_latency", cyc, 2*(IN_W + 1) + 1);

        applyStimulus(16'hFFFF, 7, 0, od, oe, cyc);
        checkOutput("illegal_err", oe, 1);
        checkOutput("illegal_data", od, 0);
        checkOutput("illegal_latency", cyc, 3);

        // 4-bit parity of in[3:0], root at node 13.
        cfgWrite(20, mkNode(0, 0, 0, 0, 1, 0));
`ifdef BDD_COMPLEMENT_EDGES_EN
        cfgWrite(10, mkNode(20, 20, 0, 0, 0, 2));
        cfgWrite(11, mkNode(10, 10, 1, 0, 0, 2));
        cfgWrite(12, mkNode(11, 11, 2, 0, 0, 2));
        cfgWrite(13, mkNode(12, 12, 3, 0, 0, 2));
`else
        cfgWrite(21, mkNode(0, 0, 0, 1, 1, 0));
        cfgWrite(10, mkNode(20, 21, 0, 0, 0, 0));
        cfgWrite(14, mkNode(21, 20, 0, 0, 0, 0));
        cfgWrite(11, mkNode(10, 14, 1, 0, 0, 0));
        cfgWrite(15, mkNode(14, 10, 1, 0, 0, 0));
        cfgWrite(12, mkNode(11, 15, 2, 0, 0, 0));
        cfgWrite(16, mkNode(15, 11, 2, 0, 0, 0));
        cfgWrite(13, mkNode(12, 16, 3, 0, 0, 0));
`endif
        applyStimulus(16'h000B, 13, 0, od, oe, cyc);
        checkOutput("parity_b_data", od, 1);
        checkOutput("parity_b_latency", cyc, 11);
        applyStimulus(16'h000F, 13, 0, od, oe, cyc);
        checkOutput("parity_f_data", od, 0);
        for (int i = 0; i < 4; i++) begin
            logic [IN_W-1:0] pv;
            pv = 16'($urandom);
            applyStimulus(pv, 13, 0, od, oe, cyc);
            checkOutput("parity_rand", od, int'(^pv[3:0]));
        end

        // Backpressure with a config write attempted while DONE is held;
        // the write must be dropped, so node 5 still reads as terminal 0.
        drop_en   = 1'b1;
        drop_addr = 8'd5;
        drop_word = mkNode(0, 0, 0, 1, 1, 0);
        runWalk("backpressure", 16'h000F, 0, 10);
        drop_en = 1'b0;
        runWalk("dropped_write", 16'h0000, 5, 0);

        // Write and acceptance in the same IDLE cycle: the walk sees new data.
        co_en   = 1'b1;
        co_addr = 8'd9;
        co_word = mkNode(0, 0, 0, 1, 1, 0);
        model_mem[9] = co_word;
        runWalk("co_write", 16'h0000, 9, 0);
        co_en = 1'b0;

        // Random tables on nodes 32-63, random vectors and roots.
        for (int n = 32; n < 64; n++) begin
            negs = 0;
`ifdef BDD_COMPLEMENT_EDGES_EN
            negs = int'($urandom_range(0, 3));
`endif
            cfgWrite(n, mkNode(32 + int'($urandom_range(0, 31)), 32 + int'($urandom_range(0, 31)),
                               int'($urandom_range(0, 17)), int'($urandom_range(0, 1)),
                               ($urandom_range(0, 2) == 0) ? 1 : 0, negs));
        end
        for (int t = 0; t < 40; t++) begin
            runWalk("random", 16'($urandom), 32 + int'($urandom_range(0, 31)), (t % 8 == 7) ? 3 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
